// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// counter sizing, reusable by a later serial adder.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..width-1, never less than one.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_subtractor_df.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor_df (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_fsm.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor_fsm
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where the block is idle
  // (busy=0, done=0); operands are captured at that edge. busy marks the
  // WIDTH bit-steps, done pulses one cycle when diff/bout become valid, and
  // the two are never high together. start in RUN/DONE is ignored.

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor_df u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            brw     <= bin;
            cnt     <= '0;
            diff_sr <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          brw     <= cell_bout;
          diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
          cnt     <= cnt + CW'(1);
          // Outputs are loaded from the final bit-step so they are valid
          // in the same cycle that done is raised.
          if (cnt == LAST) begin
            diff  <= {cell_d, diff_sr[WIDTH-1:1]};
            bout  <= cell_bout;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Directed bench for serial_subtractor_fsm (WIDTH=4): reset, basic op,
// back-to-back, boundaries, ignored start and mid-run abort.
module tb_serial_subtractor_fsm;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;
  logic [1:0] dbg_state;

  int total;
  int bad;

  serial_subtractor_fsm #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: launch one op, then observe 12 cycles #1 after each edge.
  // done_at is the observed-cycle index of the first done (c0 = after E0).
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                        input logic [3:0] prev_diff,
                        output int busy_n, output int done_n, output int done_at,
                        output int overlap, output int hold_bad,
                        output logic [3:0] rd, output logic rb);
    @(posedge clk); #1;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
    busy_n = 0; done_n = 0; done_at = -1; overlap = 0; hold_bad = 0;
    rd = 4'hx; rb = 1'bx;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) begin
        if (done_at < 0) done_at = i;
        done_n++;
        rd = diff;
        rb = bout;
      end
      if (done_at < 0 && diff !== prev_diff) hold_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] ia, input logic [3:0] ib,
                          input logic ibin, input logic [3:0] prev_diff,
                          input logic [3:0] exp_d, input logic exp_b);
    int bn, dn, da, ov, hb;
    logic [3:0] rd;
    logic rb;
    run_op(ia, ib, ibin, prev_diff, bn, dn, da, ov, hb, rd, rb);
    total++;
    if (rd !== exp_d) begin
      bad++; $display("FAIL %s diff got=%b exp=%b", name, rd, exp_d);
    end
    total++;
    if (rb !== exp_b) begin
      bad++; $display("FAIL %s bout got=%b exp=%b", name, rb, exp_b);
    end
    total++;
    if (bn !== 4) begin
      bad++; $display("FAIL %s busy_cycles got=%0d exp=4", name, bn);
    end
    total++;
    if (dn !== 1) begin
      bad++; $display("FAIL %s done_pulses got=%0d exp=1", name, dn);
    end
    total++;
    if (da !== 4) begin
      bad++; $display("FAIL %s done_latency got=%0d exp=4", name, da);
    end
    total++;
    if (ov !== 0) begin
      bad++; $display("FAIL %s busy_done_overlap got=%0d exp=0", name, ov);
    end
    total++;
    if (hb !== 0) begin
      bad++; $display("FAIL %s diff_hold got=%0d bad_cycles exp=0", name, hb);
    end
    total++;
    if (diff !== exp_d) begin
      bad++; $display("FAIL %s diff_after got=%b exp=%b", name, diff, exp_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 4'b1010; b = 4'b0101; bin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({busy, done, diff, bout} !== 7'b0) begin
        bad++;
        $display("FAIL reset_%0d busy=%b done=%b diff=%b bout=%b exp all 0", i, busy, done, diff, bout);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, diff, bout} !== 7'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b done=%b diff=%b bout=%b exp all 0", busy, done, diff, bout);
    end
  endtask

  task automatic test_basic();
    check_op("basic", 4'b0011, 4'b0101, 1'b0, 4'b0000, 4'b1110, 1'b1);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_1", 4'b1111, 4'b0001, 1'b0, 4'b1110, 4'b1110, 1'b0);
    check_op("b2b_2", 4'b1001, 4'b0110, 1'b1, 4'b1110, 4'b0010, 1'b0);
  endtask

  task automatic test_boundaries();
    check_op("bnd_0_f_1", 4'b0000, 4'b1111, 1'b1, 4'b0010, 4'b0000, 1'b1);
    check_op("bnd_f_f_1", 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1);
    check_op("bnd_zero",  4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
  endtask

  task automatic test_ignored_start();
    int extra_done, extra_busy;
    @(posedge clk); #1;
    a = 4'b0011; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // c0, RUN
    start = 1'b0;
    @(posedge clk); #1;            // c1, RUN
    a = 4'b1111; b = 4'b0000; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;            // c2
    start = 1'b0;
    @(posedge clk); #1;            // c3
    @(posedge clk); #1;            // c4, DONE
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL ign_done got=%b exp=1", done);
    end
    total++;
    if ({diff, bout} !== 5'b11101) begin
      bad++; $display("FAIL ign_result got=%b/%b exp=1110/1", diff, bout);
    end
    a = 4'b0111; b = 4'b0001; start = 1'b1;
    @(posedge clk); #1;            // c5, IDLE
    start = 1'b0;
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) extra_done++;
      if (busy) extra_busy++;
      @(posedge clk); #1;
    end
    total++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      bad++; $display("FAIL ign_retrigger done=%0d busy=%0d exp=0/0", extra_done, extra_busy);
    end
    total++;
    if ({diff, bout} !== 5'b11101) begin
      bad++; $display("FAIL ign_hold got=%b/%b exp=1110/1", diff, bout);
    end
  endtask

  task automatic test_abort();
    int dn;
    @(posedge clk); #1;
    a = 4'b1111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // c0, 1st RUN cycle
    start = 1'b0;
    @(posedge clk); #1;            // c1, 2nd RUN cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, diff, bout} !== 7'b0) begin
      bad++;
      $display("FAIL abort_outputs busy=%b done=%b diff=%b bout=%b exp all 0", busy, done, diff, bout);
    end
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    total++;
    if (dn !== 0) begin
      bad++; $display("FAIL abort_no_done got=%0d active_cycles exp=0", dn);
    end
    check_op("abort_next", 4'b0110, 4'b0011, 1'b0, 4'b0000, 4'b0011, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_ignored_start();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
